// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO-PUF evaluation controller: FSM state
// encoding and default parameter values.
package ro_puf_pkg;

   localparam int DEF_CNT_W  = 16;
   localparam int DEF_WINDOW = 1024;
   localparam int DEF_SETTLE = 4;
   localparam int DEF_NBITS  = 8;
   localparam int DEF_CH_W   = 4;

   // Evaluation FSM states; exported on the debug state signal.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_COUNT  = 3'd2,
      ST_DECIDE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/ro_puf_eval_if.sv
// Signal bundle between the evaluation controller and its environment.
//
// Handshake: start is a level that the controller samples only while
// idle; there is no ready, and a start seen while busy or done is dropped.
// resp_valid is a one-cycle pulse marking resp as complete; resp then holds
// until the next accepted start. There is no back-pressure on resp_valid.
interface ro_puf_eval_if
   import ro_puf_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int NBITS = DEF_NBITS,
   parameter int CH_W  = DEF_CH_W
) ();

   logic             start;
   logic [CH_W-1:0]  chal_seed;
   logic             ro_a;
   logic             ro_b;
   logic [CH_W-1:0]  chal_a;
   logic [CH_W-1:0]  chal_b;
   logic             busy;
   logic             resp_valid;
   logic [NBITS-1:0] resp;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   state_t           dbg_state;

   modport master (
      output start, chal_seed, ro_a, ro_b,
      input  chal_a, chal_b, busy, resp_valid, resp, cnt_a, cnt_b, dbg_state
   );

   modport slave (
      input  start, chal_seed, ro_a, ro_b,
      output chal_a, chal_b, busy, resp_valid, resp, cnt_a, cnt_b, dbg_state
   );

endinterface

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one raw oscillator: 2-FF synchronizer, a third
// flop for edge detection, and a saturating counter with clear and enable.
module ro_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ro,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic             w_rise;
   logic [CNT_W-1:0] r_cnt;

   assign w_rise = r_s2 & ~r_s3;
   assign o_cnt  = r_cnt;

   // Synchronize the asynchronous oscillator and keep one delayed copy.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_ro;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Count detected rising edges while enabled, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && w_rise && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ro_puf.sv
// RO-PUF evaluation controller. Steps a challenge pair onto the two
// oscillator muxes, lets the selection settle, counts edges of both
// oscillators over a fixed window and records (count_a > count_b) as one
// response bit, LSB first. Note rst_n is active-high despite its name.
module ro_puf_eval
   import ro_puf_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int WINDOW = DEF_WINDOW,
   parameter int SETTLE = DEF_SETTLE,
   parameter int NBITS  = DEF_NBITS,
   parameter int CH_W   = DEF_CH_W
) (
   input logic           clk,
   input logic           rst_n,
   ro_puf_eval_if.slave  bus
);

   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int K_W     = (NBITS > 1) ? $clog2(NBITS) : 1;

   state_t           r_state;
   logic [TMR_W-1:0] r_timer;
   logic [K_W-1:0]   r_k;
   logic [CH_W-1:0]  r_chal_a;
   logic [CH_W-1:0]  r_chal_b;
   logic             r_busy;
   logic             r_resp_valid;
   logic [NBITS-1:0] r_resp;
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;

   logic             w_clr;
   logic             w_en;
   logic             w_bit;
   logic [CNT_W-1:0] w_cnt_a;
   logic [CNT_W-1:0] w_cnt_b;

   // Counters are held clear while the muxes settle and run only in COUNT.
   assign w_clr = (r_state == ST_SETTLE);
   assign w_en  = (r_state == ST_COUNT);
   assign w_bit = (w_cnt_a > w_cnt_b);

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ro  (bus.ro_a),
      .i_clr (w_clr),
      .i_en  (w_en),
      .o_cnt (w_cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ro  (bus.ro_b),
      .i_clr (w_clr),
      .i_en  (w_en),
      .o_cnt (w_cnt_b)
   );

   // Evaluation sequencer with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_k          <= '0;
         r_chal_a     <= '0;
         r_chal_b     <= '0;
         r_busy       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp       <= '0;
         r_cnt_a      <= '0;
         r_cnt_b      <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state  <= ST_SETTLE;
                  r_timer  <= TMR_W'(SETTLE - 1);
                  r_k      <= '0;
                  r_chal_a <= bus.chal_seed;
                  r_chal_b <= bus.chal_seed + CH_W'(1);
                  r_busy   <= 1'b1;
                  r_resp   <= '0;
               end
            end
            ST_SETTLE: begin
               if (r_timer == '0) begin
                  r_state <= ST_COUNT;
                  r_timer <= TMR_W'(WINDOW - 1);
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end
            ST_COUNT: begin
               if (r_timer == '0) begin
                  r_state <= ST_DECIDE;
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end
            ST_DECIDE: begin
               r_resp[r_k] <= w_bit;
               r_cnt_a     <= w_cnt_a;
               r_cnt_b     <= w_cnt_b;
               if (r_k == K_W'(NBITS - 1)) begin
                  r_state      <= ST_DONE;
                  r_busy       <= 1'b0;
                  r_resp_valid <= 1'b1;
               end else begin
                  // Both selects advance together; wrap-around is intended.
                  r_state  <= ST_SETTLE;
                  r_timer  <= TMR_W'(SETTLE - 1);
                  r_k      <= r_k + K_W'(1);
                  r_chal_a <= r_chal_a + CH_W'(1);
                  r_chal_b <= r_chal_b + CH_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.chal_a     = r_chal_a;
   assign bus.chal_b     = r_chal_b;
   assign bus.busy       = r_busy;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp       = r_resp;
   assign bus.cnt_a      = r_cnt_a;
   assign bus.cnt_b      = r_cnt_b;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Bench for ro_puf_eval: reset, table-driven evaluations, randomized
// evaluations against a window/period model, abort, and counter saturation.
module tb_ro_puf_eval;
   import ro_puf_pkg::*;

   localparam int WINDOW   = 16;
   localparam int SETTLE   = 4;
   localparam int NBITS    = 4;
   localparam int CNT_W    = 8;
   localparam int CH_W     = 4;
   localparam int SAT_W    = 2;
   localparam int PER_BIT  = SETTLE + WINDOW + 1;
   localparam int DONE_CYC = NBITS * PER_BIT + 1;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ro_puf_eval_if #(.CNT_W(CNT_W), .NBITS(NBITS), .CH_W(CH_W)) bus ();
   ro_puf_eval_if #(.CNT_W(SAT_W), .NBITS(NBITS), .CH_W(CH_W)) bus2 ();

   ro_puf_eval #(.CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE),
                 .NBITS(NBITS), .CH_W(CH_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   ro_puf_eval #(.CNT_W(SAT_W), .WINDOW(WINDOW), .SETTLE(SETTLE),
                 .NBITS(NBITS), .CH_W(CH_W)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   // ---------------- oscillator generators ----------------
   // Main pair: square waves with half-periods ha_cur/hb_cur (clk cycles),
   // restarted on gen_reload so each bit sees a clean periodic waveform.
   logic ro_a_drv = 1'b0;
   logic ro_b_drv = 1'b0;
   int   ha_cur = 2;
   int   hb_cur = 4;
   int   ga_cnt = 0;
   int   gb_cnt = 0;
   bit   gen_reload = 1'b0;

   always @(negedge clk) begin
      if (gen_reload) begin
         ga_cnt = 0;
         gb_cnt = 0;
         gen_reload = 1'b0;
      end else begin
         if (ga_cnt + 1 >= ha_cur) begin ro_a_drv = ~ro_a_drv; ga_cnt = 0; end
         else ga_cnt++;
         if (gb_cnt + 1 >= hb_cur) begin ro_b_drv = ~ro_b_drv; gb_cnt = 0; end
         else gb_cnt++;
      end
   end

   // Saturation pair: ro_a2 toggles every clk (8 edges/window), ro_b2
   // every 2 clk (4 edges/window).
   logic ro_a2 = 1'b0;
   logic ro_b2 = 1'b0;
   int   g2 = 0;
   always @(negedge clk) begin
      ro_a2 = ~ro_a2;
      g2++;
      if (g2 % 2 == 0) ro_b2 = ~ro_b2;
   end

   assign bus.ro_a  = ro_a_drv;
   assign bus.ro_b  = ro_b_drv;
   assign bus2.ro_a = ro_a2;
   assign bus2.ro_b = ro_b2;

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [NBITS-1:0] exp_q[$];

   int ha_tab[NBITS];
   int hb_tab[NBITS];
   int exp_ca[NBITS];
   int exp_cb[NBITS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sample point: 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a periodic wave of half-period h gives WINDOW/(2h) rising
   // edges in any WINDOW-cycle span when 2h divides WINDOW; counts stick at max.
   function automatic int model_cnt(input int h, input int w);
      int n;
      int mx;
      n  = WINDOW / (2 * h);
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_rv"},    32'(bus.resp_valid), 32'd0);
      check({tag, "_resp"},  32'(bus.resp), 32'd0);
      check({tag, "_chal_a"}, 32'(bus.chal_a), 32'd0);
      check({tag, "_chal_b"}, 32'(bus.chal_b), 32'd0);
      check({tag, "_cnt_a"}, 32'(bus.cnt_a), 32'd0);
      check({tag, "_cnt_b"}, 32'(bus.cnt_b), 32'd0);
      check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
   endtask

   // One full evaluation on the main DUT. ha_tab/hb_tab/exp_ca/exp_cb hold the
   // per-bit waveform and expected counts; exp_resp is pushed to the queue.
   task automatic run_eval(input logic [CH_W-1:0] seed, input bit hold_start,
                           input logic [NBITS-1:0] exp_resp);
      int pulses;
      int k;
      logic [CH_W-1:0] ea;
      logic [CH_W-1:0] eb;
      logic [NBITS-1:0] qv;
      exp_q.push_back(exp_resp);
      bus.chal_seed = seed;
      bus.start = 1'b1;
      pulses = 0;
      for (int c = 1; c <= DONE_CYC; c++) begin
         tick();
         if (c == 1 && !hold_start) bus.start = 1'b0;
         if ((c - 1) % PER_BIT == 0 && c > 1) begin
            k = (c - 1) / PER_BIT - 1;
            check("cnt_a_after_decide", 32'(bus.cnt_a), 32'(exp_ca[k]));
            check("cnt_b_after_decide", 32'(bus.cnt_b), 32'(exp_cb[k]));
         end
         if ((c - 1) % PER_BIT == 0 && (c - 1) / PER_BIT < NBITS) begin
            k = (c - 1) / PER_BIT;
            ha_cur = ha_tab[k];
            hb_cur = hb_tab[k];
            gen_reload = 1'b1;
            ea = seed + CH_W'(k);
            eb = seed + CH_W'(k + 1);
            check("chal_a", 32'(bus.chal_a), 32'(ea));
            check("chal_b", 32'(bus.chal_b), 32'(eb));
            check("busy_during_eval", 32'(bus.busy), 32'd1);
         end
         if (bus.resp_valid === 1'b1) pulses++;
      end
      // Now in cycle DONE_CYC.
      check("resp_valid_at_done", 32'(bus.resp_valid), 32'd1);
      check("busy_at_done", 32'(bus.busy), 32'd0);
      qv = exp_q.pop_front();
      check("resp", 32'(bus.resp), 32'(qv));
      bus.start = 1'b0;
      check("resp_valid_pulses", 32'(pulses), 32'd1);
      tick();
      check("resp_valid_after", 32'(bus.resp_valid), 32'd0);
      check("state_idle_after", 32'(bus.dbg_state), 32'(ST_IDLE));
      tick();
      check("busy_stays_low", 32'(bus.busy), 32'd0);
      check("resp_held", 32'(bus.resp), 32'(qv));
   endtask

   typedef struct {
      logic [CH_W-1:0]  seed;
      int               ha;
      int               hb;
      bit               hold;
      logic [NBITS-1:0] exp_resp;
      int               exp_ca;
      int               exp_cb;
   } vec_t;

   vec_t vecs[6];

   // ---------------- main test ----------------
   initial begin
      int pulses;
      int waited;
      logic [NBITS-1:0] r;

      vecs[0] = '{seed: 4'd3,  ha: 2, hb: 4, hold: 1'b0, exp_resp: 4'b1111, exp_ca: 4, exp_cb: 2};
      vecs[1] = '{seed: 4'd15, ha: 2, hb: 2, hold: 1'b0, exp_resp: 4'b0000, exp_ca: 4, exp_cb: 4};
      vecs[2] = '{seed: 4'd7,  ha: 4, hb: 2, hold: 1'b1, exp_resp: 4'b0000, exp_ca: 2, exp_cb: 4};
      vecs[3] = '{seed: 4'd0,  ha: 1, hb: 8, hold: 1'b0, exp_resp: 4'b1111, exp_ca: 8, exp_cb: 1};
      vecs[4] = '{seed: 4'd9,  ha: 8, hb: 8, hold: 1'b0, exp_resp: 4'b0000, exp_ca: 1, exp_cb: 1};
      vecs[5] = '{seed: 4'd14, ha: 1, hb: 2, hold: 1'b1, exp_resp: 4'b1111, exp_ca: 8, exp_cb: 4};

      bus.start = 1'b0;
      bus.chal_seed = '0;
      bus2.start = 1'b0;
      bus2.chal_seed = '0;

      // Reset held for two cycles.
      rst_n = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset");
      check("sat_reset_busy", 32'(bus2.busy), 32'd0);
      check("sat_reset_cnt_a", 32'(bus2.cnt_a), 32'd0);
      rst_n = 1'b0;
      tick();
      check_idle_outputs("post_reset");

      // Table-driven evaluations.
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < NBITS; k++) begin
            ha_tab[k] = vecs[v].ha;
            hb_tab[k] = vecs[v].hb;
            exp_ca[k] = vecs[v].exp_ca;
            exp_cb[k] = vecs[v].exp_cb;
         end
         run_eval(vecs[v].seed, vecs[v].hold, vecs[v].exp_resp);
      end

      // Randomized evaluations with per-bit oscillator rates.
      for (int n = 0; n < 8; n++) begin
         logic [CH_W-1:0] s;
         bit hold;
         s = CH_W'($urandom_range(0, (1 << CH_W) - 1));
         hold = 1'($urandom_range(0, 1));
         r = '0;
         for (int k = 0; k < NBITS; k++) begin
            ha_tab[k] = 1 << $urandom_range(0, 3);
            hb_tab[k] = 1 << $urandom_range(0, 3);
            exp_ca[k] = model_cnt(ha_tab[k], CNT_W);
            exp_cb[k] = model_cnt(hb_tab[k], CNT_W);
            r[k] = (exp_ca[k] > exp_cb[k]);
         end
         run_eval(s, hold, r);
      end

      // Abort: reset pulse during COUNT of bit 2.
      for (int k = 0; k < NBITS; k++) begin
         ha_tab[k] = 2;
         hb_tab[k] = 4;
      end
      bus.chal_seed = 4'd3;
      bus.start = 1'b1;
      for (int c = 1; c <= 2 * PER_BIT + SETTLE + 6; c++) begin
         tick();
         if (c == 1) bus.start = 1'b0;
         if ((c - 1) % PER_BIT == 0) begin
            ha_cur = ha_tab[0];
            hb_cur = hb_tab[0];
            gen_reload = 1'b1;
         end
      end
      check("abort_state_count", 32'(bus.dbg_state), 32'(ST_COUNT));
      check("abort_partial_resp", 32'(bus.resp), 32'b0011);
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      check_idle_outputs("abort");
      pulses = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (bus.resp_valid === 1'b1) pulses++;
      end
      check("abort_no_resp_valid", 32'(pulses), 32'd0);

      // Saturation on the narrow-counter instance.
      bus2.chal_seed = 4'd5;
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      check("sat_busy", 32'(bus2.busy), 32'd1);
      waited = 1;
      while (bus2.resp_valid !== 1'b1 && waited < 300) begin
         tick();
         waited++;
      end
      if (bus2.resp_valid !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL sat_timeout: no resp_valid within %0d cycles", waited);
      end else begin
         check("sat_latency", 32'(waited), 32'(DONE_CYC));
         check("sat_cnt_a", 32'(bus2.cnt_a), 32'd3);
         check("sat_cnt_b", 32'(bus2.cnt_b), 32'd3);
         check("sat_resp", 32'(bus2.resp), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ro_puf_eval.md
# ro_puf_eval

Evaluation controller sitting directly downstream of the ring-oscillator mux pair in the RO-PUF. It steps a challenge sequence onto the two oscillator selects and counts rising edges of both selected oscillators over a fixed clk-cycle window. For each challenge it compares the two counts and assembles the resulting bits into an NBITS-wide response word. It replaces free-running, asynchronously reset counters with a single-clock, gated measurement.

## Interface
Parameters:
- CNT_W, 16: edge-counter width.
- WINDOW, 1024: count-window length in clk cycles (≥1).
- SETTLE, 4: settle cycles after each select change (≥3, covers synchronizer flush).
- NBITS, 8: response bits per evaluation.
- CH_W, 4: challenge/select width.

Ports:
- clk, in, 1: single system clock; everything is synchronous to its rising edge.
- rst_n, in, 1: synchronous, active-high reset. Named per codebase convention; high clears the block.
- start, in, 1: begin evaluation; sampled only in IDLE.
- chal_seed, in, CH_W: base challenge; captured on the accepted start.
- ro_a, in, 1: raw oscillator output, group A mux.
- ro_b, in, 1: raw oscillator output, group B mux.
- chal_a, out, CH_W: select for group A mux.
- chal_b, out, CH_W: select for group B mux.
- busy, out, 1: high from the cycle after an accepted start until DONE.
- resp_valid, out, 1: one-cycle pulse when resp is complete.
- resp, out, NBITS: response word; held until the next accepted start.
- cnt_a, out, CNT_W: count for the most recent decided bit, group A.
- cnt_b, out, CNT_W: count for the most recent decided bit, group B.

## Operation
- States:
  - IDLE
  - SETTLE: SETTLE cycles; counters held clear.
  - COUNT: WINDOW cycles; counters enabled.
  - DECIDE: 1 cycle.
  - DONE: 1 cycle.
- Transitions:
  - IDLE→SETTLE on start.
  - SETTLE→COUNT after SETTLE cycles.
  - COUNT→DECIDE after WINDOW cycles.
  - DECIDE→SETTLE if bit index k<NBITS-1, otherwise DECIDE→DONE.
  - DONE→IDLE.
- Challenge for bit k:
  - chal_a = seed+k mod 2^CH_W.
  - chal_b = seed+k+1 mod 2^CH_W (wrap-around is intended).
  - Both update on entry to SETTLE.
- Edge counting:
  - Each ro input passes through a 2-FF synchronizer.
  - A rising edge is counted when the second stage is 1 and a third flop is 0.
  - Counts saturate at 2^CNT_W-1; they do not wrap.
- DECIDE:
  - bit = (count_a > count_b); a tie gives 0.
  - resp[k] ← bit, so bit 0 is the first challenge (LSB first).
  - cnt_a/cnt_b ← counts.
- On accepted start, resp is cleared to 0 and k to 0.
- start while busy or in DONE is ignored; no queueing.
- Reset values: all outputs 0, state IDLE, k=0, counters 0, synchronizers 0.
- Reset mid-evaluation aborts immediately. No resp_valid is produced and resp reads 0 next cycle.
- Only edges slower than clk/2 are counted faithfully; aliasing above that is accepted behaviour.

## Timing
- Accepted start at cycle 0 → busy=1 and chal_a/b valid at cycle 1.
- Per bit: SETTLE+WINDOW+1 cycles.
- resp_valid high in cycle NBITS·(SETTLE+WINDOW+1)+1. busy drops in that same cycle, and resp is valid from it.
- cnt_a/cnt_b update the cycle after each DECIDE.
- An edge arriving at ro_x in the last SETTLE cycle minus 2 or later may be counted. Edges from earlier select values never are.

## Structure
- Package ro_puf_pkg holds:
  - the state enum (IDLE, SETTLE, COUNT, DECIDE, DONE);
  - default parameter constants.
- Sub-module ro_edge_counter holds the synchronizer, edge detect and saturating counter with clear/enable. It is instantiated twice.
- The FSM, challenge generation and response register live in the top block.

## Test plan
All scenarios use WINDOW=16, SETTLE=4, NBITS=4, CNT_W=8.
- Reset: rst_n=1 for 2 cycles → all outputs 0, busy=0.
- Basic response:
  - Stimulus: seed=3; ro_a toggles every 2 clk (4 edges/window), ro_b every 4 clk (2 edges).
  - Required: chal_a/chal_b step 3/4, 4/5, 5/6, 6/7; resp=4'b1111; cnt_a=4, cnt_b=2.
  - Required: resp_valid exactly at cycle 85.
- Tie and wrap:
  - Stimulus: seed=15; ro_a and ro_b identical.
  - Required: first chal_a/chal_b=15/0; resp=4'b0000.
- Saturation:
  - Stimulus: CNT_W=2; ro_a 8 edges/window, ro_b 4 edges.
  - Required: cnt_a=cnt_b=3, bit=0.
- Abort and ignore:
  - Stimulus: rst_n pulse during COUNT of bit 2.
  - Required: busy=0 and resp=0 next cycle, no resp_valid.
  - Stimulus: start held high throughout busy.
  - Required: exactly one resp_valid per evaluation.
